// File: rtl/wb_req_agent.sv
// Wishbone request agent: takes one local command, wins the shared bus through a
// round-robin arbiter, runs one classic cycle and returns a one-cycle response.
// Optional bus timeout is compiled in with `define WB_REQ_TIMEOUT_EN.
module wb_req_agent #(
  parameter logic [1:0] MY_ID  = 2'd0,
  parameter int         TO_CYC = 255
) (
  input  logic        clk,
  input  logic        rst,
  // local initiator command
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [3:0]  cmd_sel,
  // response
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  // arbiter
  output logic        arb_req,
  input  logic [1:0]  arb_gnt,
  // Wishbone master
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  output logic [3:0]  wbm_sel_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i
);

  typedef enum logic [1:0] {IDLE, REQ, BUS, RSP} state_t;

  state_t state;

  if (TO_CYC < 1 || TO_CYC > 65535) begin : g_bad_to_cyc
    $error("wb_req_agent: TO_CYC must lie in 1..65535");
  end

`ifdef WB_REQ_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TO_CYC - 1);
  logic [15:0] to_cnt;
`endif

  // Termination decision for the current BUS cycle.
  logic        term;
  logic        term_err;
  logic [31:0] term_rdata;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    term       = 1'b0;
    term_err   = 1'b0;
    term_rdata = 32'd0;
    if (state == BUS) begin
      if (wbm_err_i || wbm_ack_i) begin
        term       = 1'b1;
        term_err   = wbm_err_i;   // err beats a simultaneous ack
        term_rdata = wbm_we_o ? 32'd0 : wbm_dat_i;
      end
`ifdef WB_REQ_TIMEOUT_EN
      else if (to_cnt == TO_LAST) begin
        term     = 1'b1;
        term_err = 1'b1;
      end
`endif
    end
  end

  // NOTE: all state and outputs use non-blocking assignments so every register
  // sees pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
      arb_req   <= 1'b0;
      wbm_cyc_o <= 1'b0;
      wbm_stb_o <= 1'b0;
      wbm_we_o  <= 1'b0;
      wbm_adr_o <= 32'd0;
      wbm_dat_o <= 32'd0;
      wbm_sel_o <= 4'd0;
`ifdef WB_REQ_TIMEOUT_EN
      to_cnt    <= 16'd0;
`endif
    end else begin
      rsp_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            wbm_we_o  <= cmd_we;
            wbm_adr_o <= cmd_addr;
            wbm_dat_o <= cmd_wdata;
            wbm_sel_o <= cmd_sel;
            cmd_ready <= 1'b0;
            arb_req   <= 1'b1;
            state     <= REQ;
          end
        end
        REQ: begin
          if (arb_gnt == MY_ID) begin
            wbm_cyc_o <= 1'b1;
            wbm_stb_o <= 1'b1;
            state     <= BUS;
`ifdef WB_REQ_TIMEOUT_EN
            to_cnt    <= 16'd0;
`endif
          end
        end
        BUS: begin
          // Grant may move away here; the running cycle is never aborted.
          if (term) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            arb_req   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= term_err;
            rsp_rdata <= term_rdata;
            state     <= RSP;
          end
`ifdef WB_REQ_TIMEOUT_EN
          else begin
            to_cnt <= to_cnt + 16'd1;
          end
`endif
        end
        RSP: begin
          cmd_ready <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_req_agent.sv
// Self-checking bench for wb_req_agent: transaction-level expectations driven by the
// stimulus timeline, compared every cycle on the falling edge, plus literal spot checks.
module tb_wb_req_agent;

  localparam logic [1:0] ID = 2'd2;
  localparam int         TO = 8;
`ifdef WB_REQ_TIMEOUT_EN
  localparam int AMAX = TO;
`else
  localparam int AMAX = 12;
`endif

  logic        clk;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_sel;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        arb_req;
  logic [1:0]  arb_gnt;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
  logic [3:0]  wbm_sel_o;
  logic        wbm_ack_i, wbm_err_i;

  wb_req_agent #(.MY_ID(ID), .TO_CYC(TO)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_sel(cmd_sel),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .arb_req(arb_req), .arb_gnt(arb_gnt),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o),
    .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected observable behaviour for the current cycle.
  logic        e_on = 1'b0;
  logic        e_full, e_ready, e_areq, e_cyc, e_rv, e_we, e_err;
  logic [31:0] e_adr, e_dat, e_rdata;
  logic [3:0]  e_sel;

  always @(negedge clk) begin
    if (e_on) begin
      check("cmd_ready", cmd_ready, e_ready);
      check("arb_req", arb_req, e_areq);
      check("cyc", wbm_cyc_o, e_cyc);
      check("stb", wbm_stb_o, e_cyc);
      check("rsp_valid", rsp_valid, e_rv);
      if (e_cyc || e_full) begin
        check("we", wbm_we_o, e_we);
        check("adr", wbm_adr_o, e_adr);
        check("dat_o", wbm_dat_o, e_dat);
        check("sel", wbm_sel_o, e_sel);
      end
      if (e_rv || e_full) begin
        check("rsp_rdata", rsp_rdata, e_rdata);
        check("rsp_err", rsp_err, e_err);
      end
    end
  end

  int cyc_cycles = 0;
  int rsp_pulses = 0;
  always @(negedge clk) begin
    if (wbm_cyc_o) cyc_cycles++;
    if (rsp_valid) rsp_pulses++;
  end

  task automatic exp_idle();
    e_full = 0; e_ready = 1; e_areq = 0; e_cyc = 0; e_rv = 0;
  endtask
  task automatic exp_req();
    e_full = 0; e_ready = 0; e_areq = 1; e_cyc = 0; e_rv = 0;
  endtask
  task automatic exp_bus(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel);
    e_full = 0; e_ready = 0; e_areq = 1; e_cyc = 1; e_rv = 0;
    e_we = we; e_adr = adr; e_dat = dat; e_sel = sel;
  endtask
  task automatic exp_rsp(input logic [31:0] rd, input logic err);
    e_full = 0; e_ready = 0; e_areq = 0; e_cyc = 0; e_rv = 1;
    e_rdata = rd; e_err = err;
  endtask
  task automatic exp_reset();
    e_full = 1; e_ready = 1; e_areq = 0; e_cyc = 0; e_rv = 0;
    e_we = 0; e_adr = 0; e_dat = 0; e_sel = 0; e_rdata = 0; e_err = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] not_me();
    logic [1:0] g;
    g = 2'($urandom);
    if (g == ID) g = g + 2'd1;
    return g;
  endfunction

  // kind: 0 ack, 1 err, 2 ack+err, 3 slave never answers.
  // gdly: cycles with a foreign grant before ours; adly: BUS cycle (1-based) that terminates.
  task automatic txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                     input logic [3:0] sel, input int gdly, input int adly, input int kind,
                     input logic [31:0] rd, input bit hold,
                     output logic [31:0] o_rd, output logic o_err);
    int          term_k;
    logic        t_err;
    logic [31:0] t_rd;
    cmd_valid = 1; cmd_we = we; cmd_addr = adr; cmd_wdata = dat; cmd_sel = sel;
    arb_gnt = (gdly == 0) ? ID : not_me();
    tick();
    exp_req();
    if (!hold) cmd_valid = 1'($urandom);
    cmd_we = 1'($urandom); cmd_addr = $urandom; cmd_wdata = $urandom; cmd_sel = 4'($urandom);
    for (int k = 0; k < gdly; k++) begin
      arb_gnt = not_me(); wbm_ack_i = 1'($urandom); wbm_err_i = 1'($urandom);
      tick();
    end
    arb_gnt = ID; wbm_ack_i = 1'($urandom); wbm_err_i = 1'($urandom);
    tick();
    exp_bus(we, adr, dat, sel);
`ifdef WB_REQ_TIMEOUT_EN
    if (kind == 3 || adly > TO) begin
      term_k = TO; t_err = 1; t_rd = 0;
    end else begin
      term_k = adly; t_err = (kind != 0); t_rd = we ? 32'd0 : rd;
    end
`else
    if (kind == 3) begin
      kind = 0; adly = 1000;
    end
    term_k = adly; t_err = (kind != 0); t_rd = we ? 32'd0 : rd;
`endif
    for (int k = 1; k <= term_k; k++) begin
      wbm_ack_i = (k == adly) && (kind == 0 || kind == 2);
      wbm_err_i = (k == adly) && (kind == 1 || kind == 2);
      wbm_dat_i = (k == adly) ? rd : $urandom;
      arb_gnt = 2'($urandom);
      tick();
      if (k == term_k) exp_rsp(t_rd, t_err);
    end
    o_rd = rsp_rdata; o_err = rsp_err;
    wbm_ack_i = 1'($urandom); wbm_err_i = 1'($urandom);
    tick();
    exp_idle();
    wbm_ack_i = 0; wbm_err_i = 0;
  endtask

  task automatic idle_cycles(input int n);
    cmd_valid = 0;
    for (int i = 0; i < n; i++) begin
      wbm_ack_i = 1'($urandom); wbm_err_i = 1'($urandom);
      tick();
    end
    wbm_ack_i = 0; wbm_err_i = 0;
  endtask

  initial begin
    logic [31:0] o_rd;
    logic        o_err;
    int          c0, r0;
    rst = 1; cmd_valid = 0; cmd_we = 0; cmd_addr = 0; cmd_wdata = 0; cmd_sel = 0;
    arb_gnt = 0; wbm_dat_i = 0; wbm_ack_i = 0; wbm_err_i = 0;
    repeat (2) @(posedge clk);
    #1;
    exp_reset();
    e_on = 1;
    tick();
    rst = 0;
    tick();
    exp_idle();
    idle_cycles(2);

    // Parked grant read, ack on third BUS cycle.
    c0 = cyc_cycles; r0 = rsp_pulses;
    txn(0, 32'h1000_0010, 32'h0, 4'hF, 0, 3, 0, 32'hDEADBEEF, 0, o_rd, o_err);
    check("t035_rdata", o_rd, 32'hDEADBEEF);
    check("t035_err", o_err, 0);
    check("t035_cyc_len", cyc_cycles - c0, 3);
    check("t035_pulses", rsp_pulses - r0, 1);
    idle_cycles(1);

    // Write waits four cycles for the grant.
    c0 = cyc_cycles;
    txn(1, 32'h2000_0004, 32'h12345678, 4'hF, 4, 2, 0, 32'hCAFEF00D, 0, o_rd, o_err);
    check("t036_rdata", o_rd, 32'h0);
    check("t036_cyc_len", cyc_cycles - c0, 2);
    idle_cycles(1);

    // Simultaneous ack and err.
    r0 = rsp_pulses;
    txn(0, 32'h3000_0000, 32'h0, 4'h3, 1, 1, 2, 32'hA5A5A5A5, 0, o_rd, o_err);
    check("t037_err", o_err, 1);
    check("t037_pulses", rsp_pulses - r0, 1);
    idle_cycles(1);

    // Silent slave.
    c0 = cyc_cycles;
    txn(0, 32'h4000_0000, 32'h0, 4'hF, 0, 1, 3, 32'h55AA55AA, 0, o_rd, o_err);
`ifdef WB_REQ_TIMEOUT_EN
    check("t038_cyc_len", cyc_cycles - c0, 8);
    check("t038_err", o_err, 1);
    check("t038_rdata", o_rd, 32'h0);
`else
    check("t038_cyc_len", cyc_cycles - c0, 1000);
    check("t038_err", o_err, 0);
`endif
    idle_cycles(1);

    // Reset in the middle of a bus cycle, with an ack arriving at the same edge.
    r0 = rsp_pulses;
    cmd_valid = 1; cmd_we = 1; cmd_addr = 32'h5000_0000; cmd_wdata = 32'h0BADF00D; cmd_sel = 4'hC;
    arb_gnt = ID;
    tick();
    exp_req();
    cmd_valid = 0;
    tick();
    exp_bus(1, 32'h5000_0000, 32'h0BADF00D, 4'hC);
    tick();
    rst = 1; wbm_ack_i = 1;
    tick();
    exp_reset();
    rst = 0; wbm_ack_i = 0;
    tick();
    exp_idle();
    check("t039_no_rsp", rsp_pulses - r0, 0);
    txn(0, 32'h5000_0100, 32'h0, 4'h1, 0, 2, 0, 32'h01020304, 0, o_rd, o_err);
    check("t039_after_rdata", o_rd, 32'h01020304);

    // Back-to-back with cmd_valid held high.
    r0 = rsp_pulses;
    txn(0, 32'h6000_0000, 32'h0, 4'hF, 0, 1, 0, 32'h11111111, 1, o_rd, o_err);
    txn(1, 32'h6000_0004, 32'h22222222, 4'hF, 0, 1, 0, 32'h0, 1, o_rd, o_err);
    txn(0, 32'h6000_0008, 32'h0, 4'hF, 2, 2, 1, 32'h33333333, 1, o_rd, o_err);
    check("t040_pulses", rsp_pulses - r0, 3);
    check("t040_last_err", o_err, 1);

    // Randomized traffic.
    for (int i = 0; i < 40; i++) begin
      txn(1'($urandom), $urandom, $urandom, 4'($urandom), $urandom_range(0, 3),
          $urandom_range(1, AMAX), $urandom_range(0, 2), $urandom, 1'($urandom), o_rd, o_err);
      idle_cycles($urandom_range(0, 2));
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
